// File: rtl/lb_pkg.sv
// Shared definitions for the local-bus slave fabric: FSM states, internal
// register offsets, status word layout and the default bad-data pattern.
package lb_pkg;

   // Read-path states: idle, or waiting for an external slave to answer
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Byte offsets of the internal registers living in slot 0
   localparam logic [31:0] REG_ID      = 32'h0000_0000;
   localparam logic [31:0] REG_SCRATCH = 32'h0000_0004;
   localparam logic [31:0] REG_STATUS  = 32'h0000_0008;

   // Status word layout
   localparam int STAT_TCNT_LSB = 0;
   localparam int STAT_IRQ_BIT  = 16;
   localparam int STAT_OVL_LSB  = 24;

   // Writing this bit of the status register clears the sticky flag and counters
   localparam int STAT_CLR_BIT  = 0;

   // Pattern returned when a read cannot be served by any slave
   localparam logic [31:0] BAD_DATA_DEFAULT = 32'hDEADBEEF;

   // Assemble the status word from its fields
   function automatic logic [31:0] packStatus(input logic [7:0]  overlapCnt,
                                              input logic        irq,
                                              input logic [15:0] timeoutCnt);
      logic [31:0] s;
      s = '0;
      s[STAT_OVL_LSB +: 8]   = overlapCnt;
      s[STAT_IRQ_BIT]        = irq;
      s[STAT_TCNT_LSB +: 16] = timeoutCnt;
      return s;
   endfunction

endpackage

// File: rtl/lb_rd_timer.sv
// Loadable down-counter used to bound how long an external read may wait
// for its slave. It counts only while running and flags expiry at zero.
module lb_rd_timer #(
   parameter int W = 16
) (
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic         load_i,
   input  logic         run_i,
   input  logic [W-1:0] loadVal_i,
   output logic         expire_o
);

   logic [W-1:0] count_q;

   // Load on request, otherwise step down toward zero while the read waits
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= loadVal_i;
      end else if (run_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign expire_o = run_i && (count_q == '0);

endmodule

// File: rtl/lb_slave_mux.sv
// Local-bus fabric: decodes the host address into an internal register slot
// and N external slave slots, registers the slave strobes, and returns read
// data to the host, aborting external reads that are never answered.
module lb_slave_mux
   import lb_pkg::*;
#(
   parameter int          N_SLAVES    = 4,
   parameter int          SLOT_LSB    = 16,
   parameter int          SLOT_BITS   = 4,
   parameter int          TIMEOUT_CYC = 255,
   parameter logic [31:0] ID_VALUE    = 32'h53554D50,
   parameter logic [31:0] BAD_DATA    = BAD_DATA_DEFAULT
) (
   input  logic                     clk_lb,
   input  logic                     reset,
   input  logic                     lb_wr,
   input  logic                     lb_rd,
   input  logic [31:0]              lb_addr,
   input  logic [31:0]              lb_wr_d,
   output logic [31:0]              lb_rd_d,
   output logic                     lb_rd_rdy,
   output logic [N_SLAVES-1:0]      sl_cs,
   output logic                     sl_wr,
   output logic                     sl_rd,
   output logic [SLOT_LSB-1:0]      sl_addr,
   output logic [31:0]              sl_wr_d,
   input  logic [32*N_SLAVES-1:0]   sl_rd_d,
   input  logic [N_SLAVES-1:0]      sl_rd_rdy,
   output logic                     timeout_irq
);

   localparam logic [SLOT_BITS-1:0] LAST_SLOT   = SLOT_BITS'(N_SLAVES);
   localparam logic [SLOT_LSB-1:0]  OFF_ID      = SLOT_LSB'(REG_ID);
   localparam logic [SLOT_LSB-1:0]  OFF_SCRATCH = SLOT_LSB'(REG_SCRATCH);
   localparam logic [SLOT_LSB-1:0]  OFF_STATUS  = SLOT_LSB'(REG_STATUS);

   state_t                state_q;
   logic [N_SLAVES-1:0]   selOh_q;
   logic                  rdRdy_q;
   logic [31:0]           rdData_q;
   logic                  slWr_q;
   logic                  slRd_q;
   logic [N_SLAVES-1:0]   slCs_q;
   logic [SLOT_LSB-1:0]   slAddr_q;
   logic [31:0]           slWrData_q;
   logic [31:0]           scratch_q;
   logic [15:0]           timeoutCnt_q;
   logic [7:0]            overlapCnt_q;
   logic                  timeoutIrq_q;

   logic                  slWr_d;
   logic                  slRd_d;
   logic [N_SLAVES-1:0]   slCs_d;
   logic [SLOT_LSB-1:0]   slAddr_d;
   logic [31:0]           slWrData_d;

   logic [SLOT_BITS-1:0]  slot;
   logic [SLOT_LSB-1:0]   offset;
   logic                  isInt;
   logic                  isExt;
   logic [N_SLAVES-1:0]   slotOh;
   logic [31:0]           regRdData;
   logic                  selReady;
   logic [31:0]           selData;
   logic                  tmrExpire;
   logic                  statusClear;
   logic                  timeoutEvent;
   logic                  overlapEvent;
   logic                  unusedAddrBits;

   assign slot           = lb_addr[SLOT_LSB+SLOT_BITS-1:SLOT_LSB];
   assign offset         = lb_addr[SLOT_LSB-1:0];
   assign isInt          = (slot == '0);
   assign isExt          = (slot != '0) && (slot <= LAST_SLOT);
   assign unusedAddrBits = ^lb_addr[31:SLOT_LSB+SLOT_BITS];

   // One-hot select for the addressed external slot; zero for slot 0 or unmapped slots
   always_comb begin
      slotOh = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         slotOh[k] = (slot == SLOT_BITS'(k + 1));
      end
   end

   // Internal register read mux; unknown offsets read as zero
   always_comb begin
      regRdData = '0;
      if (offset == OFF_ID) begin
         regRdData = ID_VALUE;
      end else if (offset == OFF_SCRATCH) begin
         regRdData = scratch_q;
      end else if (offset == OFF_STATUS) begin
         regRdData = packStatus(overlapCnt_q, timeoutIrq_q, timeoutCnt_q);
      end
   end

   // Pick the ready pulse and data slice of the slave that owns the pending read
   always_comb begin
      selReady = 1'b0;
      selData  = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (selOh_q[k]) begin
            selReady = sl_rd_rdy[k] && (state_q == ST_WAIT);
            selData  = sl_rd_d[32*k +: 32];
         end
      end
   end

   // Next values of the slave strobes; write and read share the same address, so one select serves both
   always_comb begin
      slWr_d     = lb_wr && isExt;
      slRd_d     = lb_rd && isExt && (state_q == ST_IDLE);
      slCs_d     = (slWr_d || slRd_d) ? slotOh : '0;
      slAddr_d   = (slWr_d || slRd_d) ? offset : '0;
      slWrData_d = slWr_d ? lb_wr_d : '0;
   end

   // Event qualifiers feeding the status counters
   always_comb begin
      statusClear  = lb_wr && isInt && (offset == OFF_STATUS) && lb_wr_d[STAT_CLR_BIT];
      timeoutEvent = (state_q == ST_WAIT) && !selReady && tmrExpire;
      overlapEvent = (state_q == ST_WAIT) && lb_rd;
   end

   lb_rd_timer #(
      .W (16)
   ) uTimer (
      .clock_i   (clk_lb),
      .reset_i   (reset),
      .load_i    (slRd_d),
      .run_i     (state_q == ST_WAIT),
      .loadVal_i (16'(TIMEOUT_CYC)),
      .expire_o  (tmrExpire)
   );

   // Register the one-cycle slave strobes so they are idle-zero between transfers
   always_ff @(posedge clk_lb or posedge reset) begin
      if (reset) begin
         slWr_q     <= 1'b0;
         slRd_q     <= 1'b0;
         slCs_q     <= '0;
         slAddr_q   <= '0;
         slWrData_q <= '0;
      end else begin
         slWr_q     <= slWr_d;
         slRd_q     <= slRd_d;
         slCs_q     <= slCs_d;
         slAddr_q   <= slAddr_d;
         slWrData_q <= slWrData_d;
      end
   end

   // Read FSM: answer local and unmapped reads at once, otherwise wait for the slave or the timer
   always_ff @(posedge clk_lb or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         selOh_q  <= '0;
         rdRdy_q  <= 1'b0;
         rdData_q <= '0;
      end else begin
         rdRdy_q  <= 1'b0;
         rdData_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (lb_rd) begin
                  if (isInt) begin
                     rdRdy_q  <= 1'b1;
                     rdData_q <= regRdData;
                  end else if (!isExt) begin
                     rdRdy_q  <= 1'b1;
                     rdData_q <= BAD_DATA;
                  end else begin
                     selOh_q <= slotOh;
                     state_q <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (selReady) begin
                  rdRdy_q  <= 1'b1;
                  rdData_q <= selData;
                  selOh_q  <= '0;
                  state_q  <= ST_IDLE;
               end else if (tmrExpire) begin
                  rdRdy_q  <= 1'b1;
                  rdData_q <= BAD_DATA;
                  selOh_q  <= '0;
                  state_q  <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Scratch register, sticky timeout flag and saturating event counters; a clear write takes priority
   always_ff @(posedge clk_lb or posedge reset) begin
      if (reset) begin
         scratch_q    <= '0;
         timeoutCnt_q <= '0;
         overlapCnt_q <= '0;
         timeoutIrq_q <= 1'b0;
      end else begin
         if (lb_wr && isInt && (offset == OFF_SCRATCH)) begin
            scratch_q <= lb_wr_d;
         end
         if (statusClear) begin
            timeoutCnt_q <= '0;
            overlapCnt_q <= '0;
            timeoutIrq_q <= 1'b0;
         end else begin
            if (timeoutEvent) begin
               timeoutIrq_q <= 1'b1;
               if (timeoutCnt_q != 16'hFFFF) begin
                  timeoutCnt_q <= timeoutCnt_q + 16'd1;
               end
            end
            if (overlapEvent && (overlapCnt_q != 8'hFF)) begin
               overlapCnt_q <= overlapCnt_q + 8'd1;
            end
         end
      end
   end

   assign lb_rd_rdy   = rdRdy_q;
   assign lb_rd_d     = rdData_q;
   assign sl_wr       = slWr_q;
   assign sl_rd       = slRd_q;
   assign sl_cs       = slCs_q;
   assign sl_addr     = slAddr_q;
   assign sl_wr_d     = slWrData_q;
   assign timeout_irq = timeoutIrq_q;

endmodule

// File: tb/tb_lb_slave_mux.sv
// Testbench for lb_slave_mux: directed scenarios plus a randomized mix of
// bus transactions compared against a transaction-level model of the fabric.
module tb_lb_slave_mux;

   localparam int          NS  = 4;
   localparam int          T   = 8;
   localparam logic [31:0] ID  = 32'h53554D50;
   localparam logic [31:0] BAD = 32'hDEADBEEF;

   logic              clk_lb = 1'b0;
   logic              reset;
   logic              lb_wr;
   logic              lb_rd;
   logic [31:0]       lb_addr;
   logic [31:0]       lb_wr_d;
   logic [31:0]       lb_rd_d;
   logic              lb_rd_rdy;
   logic [NS-1:0]     sl_cs;
   logic              sl_wr;
   logic              sl_rd;
   logic [15:0]       sl_addr;
   logic [31:0]       sl_wr_d;
   logic [32*NS-1:0]  sl_rd_d;
   logic [NS-1:0]     sl_rd_rdy;
   logic              timeout_irq;

   int checkCount = 0;
   int passCount  = 0;

   // Reference model state
   logic [31:0] mScratch;
   int          mTcnt;
   int          mOvl;
   logic        mIrq;

   lb_slave_mux #(
      .N_SLAVES    (NS),
      .SLOT_LSB    (16),
      .SLOT_BITS   (4),
      .TIMEOUT_CYC (T),
      .ID_VALUE    (ID),
      .BAD_DATA    (BAD)
   ) dut (
      .clk_lb      (clk_lb),
      .reset       (reset),
      .lb_wr       (lb_wr),
      .lb_rd       (lb_rd),
      .lb_addr     (lb_addr),
      .lb_wr_d     (lb_wr_d),
      .lb_rd_d     (lb_rd_d),
      .lb_rd_rdy   (lb_rd_rdy),
      .sl_cs       (sl_cs),
      .sl_wr       (sl_wr),
      .sl_rd       (sl_rd),
      .sl_addr     (sl_addr),
      .sl_wr_d     (sl_wr_d),
      .sl_rd_d     (sl_rd_d),
      .sl_rd_rdy   (sl_rd_rdy),
      .timeout_irq (timeout_irq)
   );

   // Free-running local-bus clock
   always #5 clk_lb = ~clk_lb;

   task automatic tick();
      @(posedge clk_lb);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   function automatic logic [31:0] modelStatus();
      return {8'(mOvl), 7'd0, mIrq, 16'(mTcnt)};
   endfunction

   function automatic logic [31:0] modelRegRead(input logic [15:0] off);
      case (off)
         16'h0000: return ID;
         16'h0004: return mScratch;
         16'h0008: return modelStatus();
         default:  return 32'h0;
      endcase
   endfunction

   task automatic modelReset();
      mScratch = '0;
      mTcnt    = 0;
      mOvl     = 0;
      mIrq     = 1'b0;
   endtask

   task automatic busWrite(input int s, input logic [15:0] off, input logic [31:0] d);
      bit ext;
      ext = (s >= 1) && (s <= NS);
      if (s == 0 && off == 16'h0004) mScratch = d;
      if (s == 0 && off == 16'h0008 && d[0]) begin
         mTcnt = 0; mOvl = 0; mIrq = 1'b0;
      end
      lb_addr = (32'(s) << 16) | 32'(off);
      lb_wr_d = d;
      lb_wr   = 1'b1;
      tick();
      lb_wr   = 1'b0;
      checkOutput("wr_sl_wr", 32'(sl_wr), ext ? 32'd1 : 32'd0);
      checkOutput("wr_sl_cs", 32'(sl_cs), ext ? (32'd1 << (s - 1)) : 32'd0);
      if (ext) begin
         checkOutput("wr_sl_addr", 32'(sl_addr), 32'(off));
         checkOutput("wr_sl_wr_d", sl_wr_d, d);
      end
      tick();
      checkOutput("wr_sl_wr_end", 32'(sl_wr), 32'd0);
      checkOutput("wr_sl_cs_end", 32'(sl_cs), 32'd0);
   endtask

   task automatic regRead(input logic [15:0] off);
      lb_addr = 32'(off);
      lb_rd   = 1'b1;
      tick();
      lb_rd   = 1'b0;
      checkOutput("reg_rdy", 32'(lb_rd_rdy), 32'd1);
      checkOutput("reg_data", lb_rd_d, modelRegRead(off));
      tick();
      checkOutput("reg_rdy_end", 32'(lb_rd_rdy), 32'd0);
   endtask

   task automatic unmappedRead(input int s);
      lb_addr = 32'(s) << 16;
      lb_rd   = 1'b1;
      tick();
      lb_rd   = 1'b0;
      checkOutput("unm_rdy", 32'(lb_rd_rdy), 32'd1);
      checkOutput("unm_data", lb_rd_d, BAD);
      checkOutput("unm_sl_rd", 32'(sl_rd), 32'd0);
      tick();
   endtask

   // External read: the slave answers in cycle j after the read is accepted (0 = never)
   task automatic extRead(input int s, input logic [31:0] v, input int j, input bit stray, input bit ovl);
      int  expLat;
      bit  expReady;
      int  cyc;
      bit  got;
      int  other;
      other   = (s % NS) + 1;
      sl_rd_d = {$urandom(), $urandom(), $urandom(), $urandom()};
      sl_rd_d[32*(s-1) +: 32] = v;
      expReady = (j >= 1) && (j <= T + 1);
      expLat   = expReady ? j : T + 1;
      if (ovl && mOvl < 255) mOvl++;
      if (!expReady) begin
         mIrq = 1'b1;
         if (mTcnt < 65535) mTcnt++;
      end
      lb_addr = 32'(s) << 16;
      lb_rd   = 1'b1;
      tick();
      lb_rd   = 1'b0;
      checkOutput("ext_sl_rd", 32'(sl_rd), 32'd1);
      checkOutput("ext_sl_cs", 32'(sl_cs), 32'd1 << (s - 1));
      got = 1'b0;
      cyc = 1;
      while (!got && cyc <= T + 6) begin
         sl_rd_rdy = '0;
         if (cyc == j) sl_rd_rdy[s-1] = 1'b1;
         if (stray && cyc == 2) sl_rd_rdy[other-1] = 1'b1;
         if (ovl && cyc == 2) begin
            lb_addr = 32'h0;
            lb_rd   = 1'b1;
         end
         tick();
         sl_rd_rdy = '0;
         lb_rd     = 1'b0;
         if (cyc == 1) checkOutput("ext_sl_rd_pulse", 32'(sl_rd), 32'd0);
         if (lb_rd_rdy) begin
            got = 1'b1;
            checkOutput("ext_latency", 32'(cyc), 32'(expLat));
            checkOutput("ext_data", lb_rd_d, expReady ? v : BAD);
         end
         cyc++;
      end
      if (!got) begin
         checkOutput("ext_rdy_bound", 32'd0, 32'd1);
      end else begin
         tick();
         checkOutput("ext_single_pulse", 32'(lb_rd_rdy), 32'd0);
      end
      checkOutput("ext_irq", 32'(timeout_irq), 32'(mIrq));
   endtask

   // Randomized mix of transactions against the model
   task automatic applyStimulus(input int n);
      int op;
      int j;
      for (int i = 0; i < n; i++) begin
         op = $urandom_range(0, 6);
         case (op)
            0: busWrite(0, 16'h0004, $urandom());
            1: begin
               case ($urandom_range(0, 3))
                  0: regRead(16'h0000);
                  1: regRead(16'h0004);
                  2: regRead(16'h0008);
                  default: regRead(16'(12 + 4 * $urandom_range(0, 100)));
               endcase
            end
            2: busWrite($urandom_range(0, 15), 16'($urandom()), $urandom());
            3, 4: begin
               j = $urandom_range(0, 12);
               extRead($urandom_range(1, NS), $urandom(), j, 1'($urandom_range(0, 1)),
                       (j != 1) && ($urandom_range(0, 3) == 0));
            end
            5: unmappedRead($urandom_range(NS + 1, 15));
            default: busWrite(0, 16'h0008, $urandom());
         endcase
      end
   endtask

   initial begin
      reset     = 1'b1;
      lb_wr     = 1'b0;
      lb_rd     = 1'b0;
      lb_addr   = '0;
      lb_wr_d   = '0;
      sl_rd_d   = '0;
      sl_rd_rdy = '0;
      modelReset();
      tick();
      tick();
      checkOutput("rst_lb_rd_rdy", 32'(lb_rd_rdy), 32'd0);
      checkOutput("rst_lb_rd_d", lb_rd_d, 32'd0);
      checkOutput("rst_sl_cs", 32'(sl_cs), 32'd0);
      checkOutput("rst_sl_wr", 32'(sl_wr), 32'd0);
      checkOutput("rst_sl_rd", 32'(sl_rd), 32'd0);
      checkOutput("rst_sl_addr", 32'(sl_addr), 32'd0);
      checkOutput("rst_sl_wr_d", sl_wr_d, 32'd0);
      checkOutput("rst_irq", 32'(timeout_irq), 32'd0);
      reset = 1'b0;
      tick();

      // Internal registers
      regRead(16'h0000);
      regRead(16'h0008);
      busWrite(0, 16'h0004, 32'hA5A5_1234);
      regRead(16'h0004);
      checkOutput("scratch_const", lb_rd_d, 32'h0);
      busWrite(2, 16'h0010, 32'h0000_0055);

      // Slave reads: answered with a stray ready, boundary answer, and silence
      extRead(1, 32'h1111_2222, 5, 1'b1, 1'b0);
      extRead(2, 32'h3333_4444, 1, 1'b0, 1'b0);
      extRead(4, 32'h5555_6666, T + 1, 1'b0, 1'b0);
      regRead(16'h0008);
      extRead(3, 32'h7777_8888, 0, 1'b0, 1'b0);
      regRead(16'h0008);
      busWrite(0, 16'h0008, 32'h0000_0001);
      regRead(16'h0008);

      // Unmapped slot and overlapping read
      unmappedRead(7);
      extRead(1, 32'h9999_AAAA, 4, 1'b0, 1'b1);
      regRead(16'h0008);
      busWrite(0, 16'h0008, 32'h0000_0001);

      applyStimulus(80);

      // Reset while a read waits; a late ready must be ignored
      sl_rd_d = '0;
      lb_addr = 32'h0001_0000;
      lb_rd   = 1'b1;
      tick();
      lb_rd   = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput("midrst_lb_rd_rdy", 32'(lb_rd_rdy), 32'd0);
      checkOutput("midrst_sl_rd", 32'(sl_rd), 32'd0);
      checkOutput("midrst_sl_cs", 32'(sl_cs), 32'd0);
      checkOutput("midrst_irq", 32'(timeout_irq), 32'd0);
      tick();
      reset = 1'b0;
      sl_rd_rdy = 4'b0001;
      tick();
      sl_rd_rdy = '0;
      for (int k = 0; k < 3; k++) begin
         checkOutput("midrst_late_rdy", 32'(lb_rd_rdy), 32'd0);
         tick();
      end
      regRead(16'h0000);
      regRead(16'h0004);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/lb_slave_mux.md
Name: lb_slave_mux

Overview:
Parametrised local-bus fabric for the capture core. It replaces the fixed single-slave address split with N address-decoded slave slots plus a built-in register slot (ID, scratch, status). The block registers slave strobes and muxes read-back data to the host. A read timeout guarantees every host read completes.
It sits between the host local-bus bridge and the sump2 instance and any sibling slaves, all on clk_lb.

Parameters:
N_SLAVES, 4, number of external slave slots (1..15).
SLOT_LSB, 16, lowest lb_addr bit of the slot field.
SLOT_BITS, 4, width of the slot field; slot 0 is internal, slots 1..N_SLAVES are external.
TIMEOUT_CYC, 255, clk_lb cycles to wait for sl_rd_rdy before aborting a read (range 1..65535).
ID_VALUE, 32'h53554D50, constant returned at internal offset 0x0.
BAD_DATA, 32'hDEADBEEF, read data returned on timeout or unmapped slot.

Ports:
clk_lb  in  1  local-bus clock; the only clock.
reset  in  1  asynchronous, active-high reset.
lb_wr  in  1  host write strobe, one-cycle pulse.
lb_rd  in  1  host read strobe, one-cycle pulse.
lb_addr  in  32  host byte address.
lb_wr_d  in  32  host write data.
lb_rd_d  out  32  read data, valid only while lb_rd_rdy=1, otherwise 0.
lb_rd_rdy  out  1  one-cycle read-complete pulse.
sl_cs  out  N_SLAVES  one-hot slave select, asserted with sl_wr/sl_rd.
sl_wr  out  1  registered write strobe to slaves.
sl_rd  out  1  registered read strobe to slaves.
sl_addr  out  SLOT_LSB  registered offset within the slot (lb_addr[SLOT_LSB-1:0]).
sl_wr_d  out  32  registered write data.
sl_rd_d  in  32*N_SLAVES  packed slave read data; slave k (1-based) occupies bits [32k-1:32k-32].
sl_rd_rdy  in  N_SLAVES  per-slave read-ready pulses.
timeout_irq  out  1  sticky flag, set on any read timeout.

Behaviour:
- Reset values: every output is 0; state is IDLE; scratch=0; timeout count=0; overlap count=0.
- Slot decode: slot = lb_addr[SLOT_LSB+SLOT_BITS-1:SLOT_LSB].
- Writes, accepted in any state:
  - External slot: sl_wr, sl_cs[slot-1], sl_addr and sl_wr_d are asserted exactly 1 cycle after lb_wr, for 1 cycle.
  - Slot 0, offset 0x4: loads scratch.
  - Slot 0, offset 0x8: a write with bit0=1 clears timeout_irq and both counters.
  - All other writes are dropped silently.
- Slot 0 read map:
  - 0x0 returns ID_VALUE.
  - 0x4 returns scratch.
  - 0x8 returns {overlap_cnt[7:0], 7'd0, timeout_irq, timeout_cnt[15:0]}.
  - Any other offset returns 0.
- State machine, states IDLE and WAIT:
  - IDLE, lb_rd to slot 0: lb_rd_rdy is asserted 1 cycle later with the register value. Stay in IDLE.
  - IDLE, lb_rd to an unmapped slot (slot>N_SLAVES): lb_rd_rdy is asserted 1 cycle later with BAD_DATA. Stay in IDLE.
  - IDLE, lb_rd to an external slot: sl_rd and sl_cs are asserted 1 cycle later for 1 cycle. The selected slot is latched and the wait counter is loaded with TIMEOUT_CYC. Go to WAIT.
  - WAIT, sl_rd_rdy[sel]=1: the slice is captured, and lb_rd_rdy plus the data are asserted the next cycle. Go to IDLE. The minimum external read latency is therefore 3 cycles when the slave answers the cycle after sl_rd.
  - WAIT, counter reaches 0 without a ready: return BAD_DATA with lb_rd_rdy, increment timeout_cnt (saturating at 16'hFFFF), set timeout_irq. Go to IDLE.
  - WAIT, new lb_rd: the read is ignored (no response) and overlap_cnt increments (saturating at 8'hFF).
- sl_rd_rdy from a non-selected slave, or any sl_rd_rdy in IDLE, is ignored.
- Ready and timeout in the same cycle: ready wins, and no timeout is recorded.
- A write and a read pending together are both forwarded; sl_wr and sl_rd may assert in the same cycle.
- The combined slave-strobe output (sl_wr, sl_rd, sl_cs, sl_addr, sl_wr_d) is driven as shown; when idle, all of these are 0.
- Reset mid-read: the FSM returns to IDLE with no lb_rd_rdy; a late sl_rd_rdy after reset is ignored.

Decomposition:
- Package lb_pkg holds:
  - State encoding (ST_IDLE, ST_WAIT).
  - Internal register offsets (REG_ID=0x0, REG_SCRATCH=0x4, REG_STATUS=0x8).
  - Status field positions.
  - A default BAD_DATA constant.
- One sub-module, lb_rd_timer: a loadable down-counter with load/run/expire. Everything else stays in lb_slave_mux.

Test Plan:
- Reset, then read 0x0000_0000 -> lb_rd_rdy exactly 1 cycle later, data 0x53554D50. Read 0x0000_0008 -> 0.
- Write 0x0000_0004=0xA5A5_1234, then read it back -> 0xA5A51234. Write slot 2 (0x0002_0010=0x55) -> sl_wr, sl_cs=4'b0010, sl_addr=0x10 and sl_wr_d=0x55 all asserted 1 cycle after lb_wr, for 1 cycle.
- Read slot 1 with a model slave answering 0x1111_2222 at 5 cycles after sl_rd -> a single lb_rd_rdy with 0x11112222. A stray sl_rd_rdy[2] during the wait produces no response.
- Read slot 3 with a silent slave and TIMEOUT_CYC=8 -> lb_rd_rdy with 0xDEADBEEF roughly 10 cycles after lb_rd. Status then reads 0x0001_0001. Writing 0x1 to 0x8 clears status to 0.
- Read an unmapped slot (0x0007_0000 with N_SLAVES=4) -> BAD_DATA 1 cycle later, and no sl_rd asserted. A second lb_rd issued during a WAIT makes overlap_cnt read 1.
- Assert reset 2 cycles into a WAIT -> all outputs 0 immediately. A slave ready arriving after reset produces no lb_rd_rdy. A subsequent read of 0x0 completes normally.
